record_serializer: RTL and testbench
====================================

RECORD_SERIALIZER -- requirements
Module: record_serializer

Interface
REQ-001 SHALL have parameter REC_W, default 48, record width in bits read from the record FIFO.
REQ-002 SHALL have parameter LOST_CNT_W, default 16, width of the lost-record counter.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  permits new FIFO reads when high.
REQ-006 SHALL have port fifo_empty  input  1  record FIFO empty flag.
REQ-007 SHALL have port fifo_rdreq  output  1  one-cycle read strobe to the record FIFO.
REQ-008 SHALL have port fifo_q  input  REC_W  FIFO read data, valid the cycle after fifo_rdreq (non-show-ahead).
REQ-009 SHALL have port rec_lost  input  1  pulse per record dropped upstream (record_rdy while FIFO full).
REQ-010 SHALL have port out_data  output  8  serialized byte, MSB-first.
REQ-011 SHALL have port out_valid  output  1  out_data holds a valid byte.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the byte when high with out_valid.

Function
REQ-013 SHALL implement states IDLE, LATCH, SEND.
REQ-014 In IDLE with enable=1, fifo_empty=0 and no marker pending, SHALL assert fifo_rdreq for exactly one cycle and go to LATCH.
REQ-015 In LATCH SHALL load fifo_q into a REC_W shift register, clear byte index to 0, and go to SEND.
REQ-016 In SEND SHALL drive out_valid=1 and out_data=shift[REC_W-1 -: 8].
REQ-017 On out_valid && out_ready SHALL shift the register left by 8 and increment byte index; after acceptance of byte REC_W/8-1 (index 5) SHALL return to IDLE.
REQ-018 out_data SHALL stay constant while out_valid=1 and out_ready=0.
REQ-019 Latency: fifo_rdreq in cycle N -> first out_valid in cycle N+2; with out_ready held high, one record per 8 cycles.
REQ-020 fifo_rdreq SHALL never assert when fifo_empty=1 or outside IDLE.
REQ-021 Deasserting enable mid-record SHALL NOT abort the record; the remaining bytes complete, then no further reads occur.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 On reset: state=IDLE, fifo_rdreq=0, out_valid=0, out_data=8'h00, shift register and byte index 0, lost counter 0, marker pending 0.
REQ-024 Reset mid-record SHALL discard the partial record; bytes not yet accepted are never emitted.

Configuration
REQ-025 Macro LOST_MARKER_EN SHALL compile in lost-record reporting.
REQ-026 With LOST_MARKER_EN: each rec_lost cycle SHALL increment a LOST_CNT_W counter saturating at all-ones, and set marker pending.
REQ-027 With LOST_MARKER_EN: in IDLE a pending marker SHALL take priority over FIFO reads; the shift register loads {1'b1, (REC_W-1-LOST_CNT_W)'b0, lost_count} and goes directly to SEND (no fifo_rdreq).
REQ-028 With LOST_MARKER_EN: at marker load the counter SHALL clear to 0, or to 1 if rec_lost is high in that same cycle (pending stays set).
REQ-029 Without LOST_MARKER_EN: rec_lost SHALL be ignored, no counter logic exists, no marker is ever emitted; port list unchanged.
REQ-030 Data records SHALL carry bit REC_W-1 = 0 as supplied upstream; markers are distinguished solely by bit REC_W-1 = 1.

Structure
REQ-031 Package record_pkg SHALL hold REC_W, BYTES_PER_REC (6), MARKER_BIT (47), LOST_CNT_W and the state encoding.
REQ-032 Sub-module lost_counter (saturating counter, pending flag, clear-on-load) SHALL be instantiated only under LOST_MARKER_EN.

Verification
REQ-033 One record 48'h0123_4567_89AB in FIFO, enable=1, out_ready=1 -> bytes 01,23,45,67,89,AB on six consecutive cycles, first at rdreq+2.
REQ-034 Same record, out_ready toggled 1,0,0,1,... -> byte sequence unchanged, out_data stable during stalls, exactly one fifo_rdreq.
REQ-035 Three records queued, enable dropped during byte 2 of first -> first record completes, no further fifo_rdreq.
REQ-036 LOST_MARKER_EN, 3 rec_lost pulses while FIFO has a record -> marker bytes 80,00,00,00,00,03 precede the data record; counter then 0.
REQ-037 LOST_MARKER_EN, 70000 rec_lost pulses -> marker low 16 bits FFFF (saturation).
REQ-038 reset asserted after byte 3 accepted -> out_valid=0 next cycle; next record starts at byte 0 after reset release.

Source files
------------

// File: rtl/record_pkg.sv
// Shared constants and FSM encoding for the record serializer.
package record_pkg;
    localparam int REC_W         = 48;
    localparam int BYTES_PER_REC = REC_W / 8;
    localparam int MARKER_BIT    = REC_W - 1;
    localparam int LOST_CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SEND  = 2'd2
    } state_t;
endpackage

// File: rtl/lost_counter.sv
// Saturating lost-record counter with a pending flag; only built with LOST_MARKER_EN.
module lost_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         pending
);
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            pending <= 1'b0;
        end else if (clr) begin
            // A loss in the same cycle as the marker load starts the next marker.
            count   <= {{(W-1){1'b0}}, inc};
            pending <= inc;
        end else if (inc) begin
            pending <= 1'b1;
            if (count != {W{1'b1}})
                count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/record_serializer.sv
// Reads REC_W-bit records from a non-show-ahead FIFO and emits them MSB-first as bytes.
// Define LOST_MARKER_EN to interleave lost-record marker records.
module record_serializer #(
    parameter int REC_W      = record_pkg::REC_W,
    parameter int LOST_CNT_W = record_pkg::LOST_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    output logic             fifo_rdreq,
    input  logic [REC_W-1:0] fifo_q,
    input  logic             rec_lost,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    import record_pkg::*;

    localparam int NBYTES = REC_W / 8;
    localparam int IDX_W  = $clog2(NBYTES);

    state_t             state;
    logic [REC_W-1:0]   shift;
    logic [IDX_W-1:0]   byte_idx;
    logic               marker_pend;
    logic               marker_load;
    logic [LOST_CNT_W-1:0] lost_count;
    logic [REC_W-1:0]   marker_rec;
    logic               can_read;

    // The cycle in IDLE with fifo_rdreq high is the read issue; markers wait for it.
    assign marker_load = (state == IDLE) && !fifo_rdreq && marker_pend;
    assign can_read    = enable && !fifo_empty && !marker_pend;
    assign marker_rec  = {1'b1, {(REC_W-1-LOST_CNT_W){1'b0}}, lost_count};

`ifdef LOST_MARKER_EN
    lost_counter #(.W(LOST_CNT_W)) u_lost_counter (
        .clk     (clk),
        .reset   (reset),
        .inc     (rec_lost),
        .clr     (marker_load),
        .count   (lost_count),
        .pending (marker_pend)
    );
`else
    logic unused_rec_lost;
    assign unused_rec_lost = rec_lost;
    assign lost_count      = '0;
    assign marker_pend     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fifo_rdreq <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            shift      <= '0;
            byte_idx   <= '0;
        end else begin
            fifo_rdreq <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_rdreq) begin
                        state <= LATCH;
                    end else if (marker_load) begin
                        shift     <= marker_rec;
                        byte_idx  <= '0;
                        out_data  <= marker_rec[REC_W-1 -: 8];
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end else if (can_read) begin
                        fifo_rdreq <= 1'b1;
                    end
                end
                LATCH: begin
                    shift     <= fifo_q;
                    byte_idx  <= '0;
                    out_data  <= fifo_q[REC_W-1 -: 8];
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        shift    <= shift << 8;
                        byte_idx <= byte_idx + 1'b1;
                        out_data <= shift[REC_W-9 -: 8];
                        if (byte_idx == IDX_W'(NBYTES-1)) begin
                            // Issue the next read on the way back to IDLE to keep 8 cycles/record.
                            out_valid  <= 1'b0;
                            state      <= IDLE;
                            fifo_rdreq <= can_read;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_record_serializer.sv
// Randomized self-checking bench for record_serializer with a queue-based FIFO and byte-stream model.
module tb_record_serializer;
    logic        clk = 1'b0;
    logic        reset, enable, fifo_empty, fifo_rdreq, rec_lost, out_valid, out_ready;
    logic [47:0] fifo_q;
    logic [7:0]  out_data;

    int n_checks = 0;
    int n_err    = 0;

    logic [47:0] fifo_mem[$];
    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];
    int          got_cyc[$];
    int cyc, rd_cnt, rd_cyc, rd_bad, stall_bad, first_cyc;
    bit first_seen, stall_prev;
    logic [7:0] stall_data;

    record_serializer #(.REC_W(48), .LOST_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q), .rec_lost(rec_lost),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // One clock: observe at the negedge, then model the FIFO read just after the posedge.
    task automatic tick();
        logic rd;
        cyc++;
        rd = fifo_rdreq;
        if (!reset) begin
            if (fifo_rdreq) begin
                rd_cnt++;
                rd_cyc = cyc;
                if (fifo_empty) rd_bad++;
            end
            if (out_valid && !first_seen) begin
                first_seen = 1'b1;
                first_cyc  = cyc;
            end
            if (stall_prev && (!out_valid || out_data !== stall_data)) stall_bad++;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                got_cyc.push_back(cyc);
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        #1;
        if (rd && fifo_mem.size() > 0) fifo_q = fifo_mem.pop_front();
        fifo_empty = (fifo_mem.size() == 0);
        @(negedge clk);
    endtask

    task automatic push_rec(input logic [47:0] rec);
        fifo_mem.push_back(rec);
        fifo_empty = 1'b0;
    endtask

    task automatic add_exp(input logic [47:0] rec);
        logic [47:0] t;
        for (int i = 0; i < 6; i++) begin
            t = rec >> (8 * (5 - i));
            exp_q.push_back(t[7:0]);
        end
    endtask

    function automatic logic [47:0] rand_rec();
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        return {1'b0, a[14:0], b};
    endfunction

    task automatic run_until(input int n, input int budget);
        for (int k = 0; k < budget && got.size() < n; k++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; out_ready = 1'b0; rec_lost = 1'b0;
        fifo_mem.delete();
        fifo_empty = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        got.delete(); got_cyc.delete(); exp_q.delete();
        rd_cnt = 0; rd_bad = 0; stall_bad = 0; first_seen = 1'b0; stall_prev = 1'b0;
    endtask

    task automatic test_reset();
        fifo_q = '0;
        push_rec(48'h0123_4567_89AB);
        reset = 1'b1; enable = 1'b1; out_ready = 1'b1; rec_lost = 1'b0;
        repeat (3) tick();
        n_checks++; if (fifo_rdreq !== 1'b0) begin n_err++; $display("FAIL reset_rdreq got %b exp 0", fifo_rdreq); end
        n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        n_checks++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h exp 00", out_data); end
    endtask

    task automatic test_single();
        logic [47:0] rec;
        for (int t = 0; t < 3; t++) begin
            do_reset();
            rec = (t == 0) ? 48'h0123_4567_89AB : rand_rec();
            push_rec(rec); add_exp(rec);
            enable = 1'b1; out_ready = 1'b1;
            run_until(6, 40);
            repeat (10) tick();
            n_checks++; if (got.size() != 6) begin n_err++; $display("FAIL single_count rec %0d got %0d exp 6", t, got.size()); end
            for (int i = 0; i < 6 && i < got.size(); i++) begin
                n_checks++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL single_byte%0d got %h exp %h", i, got[i], exp_q[i]); end
            end
            n_checks++; if (first_cyc - rd_cyc != 2) begin n_err++; $display("FAIL single_latency got %0d exp 2", first_cyc - rd_cyc); end
            if (got.size() == 6) begin
                n_checks++; if (got_cyc[5] - got_cyc[0] != 5) begin n_err++; $display("FAIL single_consecutive got %0d exp 5", got_cyc[5] - got_cyc[0]); end
            end
            n_checks++; if (rd_cnt != 1) begin n_err++; $display("FAIL single_rdreq got %0d exp 1", rd_cnt); end
        end
    endtask

    task automatic test_stall();
        logic [47:0] rec;
        int pat[4] = '{1, 0, 0, 1};
        do_reset();
        for (int r = 0; r < 3; r++) begin rec = rand_rec(); push_rec(rec); add_exp(rec); end
        enable = 1'b1;
        for (int k = 0; k < 400 && got.size() < 18; k++) begin
            out_ready = (got.size() < 6) ? pat[k % 4][0] : 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;
        repeat (10) tick();
        n_checks++; if (got.size() != 18) begin n_err++; $display("FAIL stall_count got %0d exp 18", got.size()); end
        for (int i = 0; i < 18 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_byte%0d got %h exp %h", i, got[i], exp_q[i]); end
        end
        n_checks++; if (stall_bad != 0) begin n_err++; $display("FAIL stall_stable got %0d changes exp 0", stall_bad); end
        n_checks++; if (rd_cnt != 3) begin n_err++; $display("FAIL stall_rdreq got %0d exp 3", rd_cnt); end
        n_checks++; if (rd_bad != 0) begin n_err++; $display("FAIL stall_rd_empty got %0d exp 0", rd_bad); end
    endtask

    task automatic test_back_to_back();
        logic [47:0] rec;
        do_reset();
        for (int r = 0; r < 4; r++) begin rec = rand_rec(); push_rec(rec); add_exp(rec); end
        enable = 1'b1; out_ready = 1'b1;
        run_until(24, 80);
        n_checks++; if (got.size() != 24) begin n_err++; $display("FAIL b2b_count got %0d exp 24", got.size()); end
        for (int i = 0; i < 24 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_byte%0d got %h exp %h", i, got[i], exp_q[i]); end
        end
        for (int r = 1; r < 4 && 6 * r < got.size(); r++) begin
            n_checks++; if (got_cyc[6*r] - got_cyc[6*(r-1)] != 8) begin
                n_err++; $display("FAIL b2b_period rec%0d got %0d exp 8", r, got_cyc[6*r] - got_cyc[6*(r-1)]);
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [47:0] rec;
        do_reset();
        for (int r = 0; r < 3; r++) begin rec = rand_rec(); push_rec(rec); if (r == 0) add_exp(rec); end
        enable = 1'b1; out_ready = 1'b1;
        run_until(1, 20);
        enable = 1'b0;
        repeat (40) tick();
        n_checks++; if (got.size() != 6) begin n_err++; $display("FAIL endrop_count got %0d exp 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL endrop_byte%0d got %h exp %h", i, got[i], exp_q[i]); end
        end
        n_checks++; if (rd_cnt != 1) begin n_err++; $display("FAIL endrop_rdreq got %0d exp 1", rd_cnt); end
        n_checks++; if (fifo_mem.size() != 2) begin n_err++; $display("FAIL endrop_fifo_left got %0d exp 2", fifo_mem.size()); end
    endtask

    task automatic test_reset_mid();
        logic [47:0] a, b, t;
        do_reset();
        a = rand_rec(); b = rand_rec();
        push_rec(a); push_rec(b);
        for (int i = 0; i < 3; i++) begin t = a >> (8 * (5 - i)); exp_q.push_back(t[7:0]); end
        add_exp(b);
        enable = 1'b1; out_ready = 1'b1;
        run_until(3, 20);
        reset = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b exp 0", out_valid); end
        reset = 1'b0;
        run_until(9, 40);
        repeat (5) tick();
        n_checks++; if (got.size() != 9) begin n_err++; $display("FAIL rstmid_count got %0d exp 9", got.size()); end
        for (int i = 0; i < 9 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL rstmid_byte%0d got %h exp %h", i, got[i], exp_q[i]); end
        end
    endtask

`ifdef LOST_MARKER_EN
    task automatic test_marker();
        logic [47:0] a, b;
        do_reset();
        a = rand_rec(); b = rand_rec();
        push_rec(a);
        enable = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 10 && !out_valid; k++) tick();
        push_rec(b);
        rec_lost = 1'b1; repeat (3) tick(); rec_lost = 1'b0;
        repeat (3) tick();
        add_exp(a); add_exp({1'b1, 31'b0, 16'd3}); add_exp(b);
        out_ready = 1'b1;
        run_until(18, 60);
        // A single further loss must report 1, proving the counter cleared at load.
        enable = 1'b0;
        rec_lost = 1'b1; tick(); rec_lost = 1'b0;
        add_exp({1'b1, 31'b0, 16'd1});
        run_until(24, 40);
        n_checks++; if (got.size() != 24) begin n_err++; $display("FAIL marker_count got %0d exp 24", got.size()); end
        for (int i = 0; i < 24 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL marker_byte%0d got %h exp %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_saturate();
        logic [47:0] a;
        do_reset();
        a = rand_rec();
        push_rec(a);
        enable = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 10 && !out_valid; k++) tick();
        rec_lost = 1'b1; repeat (70000) tick(); rec_lost = 1'b0;
        tick();
        add_exp(a); add_exp({1'b1, 31'b0, 16'hFFFF});
        out_ready = 1'b1;
        run_until(12, 40);
        n_checks++; if (got.size() != 12) begin n_err++; $display("FAIL sat_count got %0d exp 12", got.size()); end
        for (int i = 0; i < 12 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL sat_byte%0d got %h exp %h", i, got[i], exp_q[i]); end
        end
    endtask
`else
    task automatic test_lost_ignored();
        logic [47:0] rec;
        do_reset();
        enable = 1'b1; out_ready = 1'b1;
        rec_lost = 1'b1; repeat (5) tick(); rec_lost = 1'b0;
        repeat (10) tick();
        n_checks++; if (got.size() != 0) begin n_err++; $display("FAIL lost_ignored_bytes got %0d exp 0", got.size()); end
        rec = rand_rec(); push_rec(rec); add_exp(rec);
        run_until(6, 40);
        repeat (5) tick();
        n_checks++; if (got.size() != 6) begin n_err++; $display("FAIL lost_ignored_count got %0d exp 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_checks++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL lost_ignored_byte%0d got %h exp %h", i, got[i], exp_q[i]); end
        end
    endtask
`endif

    initial begin
        cyc = 0; rd_cnt = 0; rd_cyc = 0; rd_bad = 0; stall_bad = 0; first_cyc = 0;
        first_seen = 1'b0; stall_prev = 1'b0; stall_data = 8'h00;
        fifo_empty = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
`ifdef LOST_MARKER_EN
        test_marker();
        test_saturate();
`else
        test_lost_ignored();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
